// File: rtl/uart_param_core_pkg.sv
// Shared definitions for uart_param_core.
// Contents:
//   ParityNone/ParityOdd/ParityEven - encodings of the PARITY parameter
//   StIdle..StStop                  - state encodings shared by the TX and RX FSMs
//   parity_bit()                    - line value of the parity bit for a given data XOR
package uart_param_core_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityOdd  = 1;
  localparam int unsigned ParityEven = 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // data_xor is the XOR of all data bits. Even parity sends it unchanged so the
  // total count of ones is even; odd parity sends its inverse.
  function automatic logic parity_bit(input logic data_xor, input int unsigned parity);
    case (parity)
      ParityOdd:  return ~data_xor;
      ParityEven: return data_xor;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_param_core_bit_timer.sv
// Down-counting bit timer shared by the UART TX and RX paths.
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset, clears the count
//   load_i      - load load_val_i into the counter (takes priority over counting)
//   load_val_i  - cycles until the next tick, minus one
//   en_i        - count enable; tick_o is only asserted while enabled
//   tick_o      - high in the cycle the count sits at zero
// The counter saturates at zero rather than wrapping; the owner reloads it on tick.
module uart_param_core_bit_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: TX serializer and RX deserializer with configurable
// word width, baud divisor, parity and stop bits. RX reports parity and framing errors.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset; aborts any frame in progress
//   i_rx        - asynchronous serial input, idle high
//   i_tx_data   - word to send, latched when i_tx_stb is accepted
//   i_tx_stb    - send request, accepted only while TX is idle
//   o_tx        - serial output, idle high
//   o_tx_busy   - high while a TX frame is in progress
//   o_rx_data   - last received word, held until the next frame completes
//   o_rx_valid  - one-cycle pulse per completed RX frame
//   o_rx_perr   - parity error of the last frame, held
//   o_rx_ferr   - first stop bit sampled low in the last frame, held
module uart_param_core
  import uart_param_core_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_stb,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_perr,
  output logic                 o_rx_ferr
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  // Timer tick fires load+1 cycles after the load, so full bits load CLKS_PER_BIT-1.
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  // RX start: the edge-detect cycle is already one cycle into the start bit, so the
  // first sample lands CLKS_PER_BIT/2 cycles after the edge.
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);
  localparam bit              HasParity = (PARITY != ParityNone);

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  logic [2:0]           tx_state_q, tx_state_d;
  logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_load, tx_tick;

  uart_param_core_bit_timer #(
    .CntW (CntW)
  ) u_tx_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tx_load),
    .load_val_i (BitLoad),
    .en_i       (tx_state_q != StIdle),
    .tick_o     (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (i_tx_stb) begin
          tx_state_d = StStart;
          tx_shift_d = i_tx_data;
          tx_par_d   = parity_bit(^i_tx_data, PARITY);
          tx_d       = 1'b0;
          tx_load    = 1'b1;
        end
      end
      StStart: begin
        if (tx_tick) begin
          tx_state_d = StData;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_load    = 1'b1;
        end
      end
      StData: begin
        if (tx_tick) begin
          tx_load = 1'b1;
          if (tx_idx_q == LastData) begin
            tx_idx_d = '0;
            if (HasParity) begin
              tx_state_d = StParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = StStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + IdxW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      StParity: begin
        if (tx_tick) begin
          tx_state_d = StStop;
          tx_idx_d   = '0;
          tx_d       = 1'b1;
          tx_load    = 1'b1;
        end
      end
      StStop: begin
        if (tx_tick) begin
          if (tx_idx_q == LastStop) begin
            tx_state_d = StIdle;
          end else begin
            tx_idx_d = tx_idx_q + IdxW'(1);
            tx_load  = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = StIdle;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = (tx_state_q != StIdle);

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_err_q, rx_par_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_load, rx_tick;
  logic [CntW-1:0]      rx_load_val;

  uart_param_core_bit_timer #(
    .CntW (CntW)
  ) u_rx_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (rx_load),
    .load_val_i (rx_load_val),
    .en_i       (rx_state_q != StIdle),
    .tick_o     (rx_tick)
  );

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_err_d = rx_par_err_q;
    rx_data_d    = rx_data_q;
    rx_perr_d    = rx_perr_q;
    rx_ferr_d    = rx_ferr_q;
    rx_valid_d   = 1'b0;
    rx_load      = 1'b0;
    rx_load_val  = BitLoad;
    case (rx_state_q)
      StIdle: begin
        // Edge rather than level: after a break the line must return high before
        // another frame can start.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d  = StStart;
          rx_load     = 1'b1;
          rx_load_val = HalfLoad;
        end
      end
      StStart: begin
        if (rx_tick) begin
          if (rx_sync_q) begin
            rx_state_d = StIdle;
          end else begin
            rx_state_d   = StData;
            rx_idx_d     = '0;
            rx_par_err_d = 1'b0;
            rx_load      = 1'b1;
          end
        end
      end
      StData: begin
        if (rx_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load    = 1'b1;
          if (rx_idx_q == LastData) begin
            rx_state_d = HasParity ? StParity : StStop;
          end else begin
            rx_idx_d = rx_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (rx_tick) begin
          rx_par_err_d = (rx_sync_q != parity_bit(^rx_shift_q, PARITY));
          rx_state_d   = StStop;
          rx_load      = 1'b1;
        end
      end
      StStop: begin
        // Only the first stop bit is checked; leaving at mid-stop lets the next
        // start edge be caught whether the sender uses one or two stop bits.
        if (rx_tick) begin
          rx_data_d  = rx_shift_q;
          rx_perr_d  = HasParity && rx_par_err_q;
          rx_ferr_d  = ~rx_sync_q;
          rx_valid_d = 1'b1;
          rx_state_d = StIdle;
        end
      end
      default: begin
        rx_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= StIdle;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_err_q <= 1'b0;
      rx_data_q    <= '0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_err_q <= rx_par_err_d;
      rx_data_q    <= rx_data_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_perr  = rx_perr_q;
  assign o_rx_ferr  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Self-checking bench for uart_param_core. Two instances: an 8E1 core whose RX can be
// looped back from its own TX or driven directly, and a 7O2 core in permanent loopback.
module tb_uart_param_core;

  localparam int Cpb = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8 data bits, even parity, 1 stop bit
  logic       loop_a, rx_drv_a, rx_a, tx_a, busy_a, tx_stb_a, valid_a, perr_a, ferr_a;
  logic [7:0] tx_data_a, rx_data_a;
  assign rx_a = loop_a ? tx_a : rx_drv_a;

  uart_param_core #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (Cpb),
    .PARITY       (2),
    .STOP_BITS    (1)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rx_a),
    .i_tx_data  (tx_data_a),
    .i_tx_stb   (tx_stb_a),
    .o_tx       (tx_a),
    .o_tx_busy  (busy_a),
    .o_rx_data  (rx_data_a),
    .o_rx_valid (valid_a),
    .o_rx_perr  (perr_a),
    .o_rx_ferr  (ferr_a)
  );

  // 7 data bits, odd parity, 2 stop bits, looped back
  logic       tx_b, busy_b, tx_stb_b, valid_b, perr_b, ferr_b;
  logic [6:0] tx_data_b, rx_data_b;

  uart_param_core #(
    .DATA_BITS    (7),
    .CLKS_PER_BIT (Cpb),
    .PARITY       (1),
    .STOP_BITS    (2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (tx_b),
    .i_tx_data  (tx_data_b),
    .i_tx_stb   (tx_stb_b),
    .o_tx       (tx_b),
    .o_tx_busy  (busy_b),
    .o_rx_data  (rx_data_b),
    .o_rx_valid (valid_b),
    .o_rx_perr  (perr_b),
    .o_rx_ferr  (ferr_b)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  rec_t rx_a_q[$];
  rec_t rx_b_q[$];
  int   busy_a_q[$];
  int   busy_b_q[$];
  int   busy_a_run = 0;
  int   busy_b_run = 0;
  logic busy_a_prev = 1'b0;
  logic busy_b_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Record every delivered frame and the length of every busy run.
  always @(negedge clk) begin
    if (valid_a === 1'b1) rx_a_q.push_back({1'b0, rx_data_a, perr_a, ferr_a});
    if (valid_b === 1'b1) rx_b_q.push_back({2'b0, rx_data_b, perr_b, ferr_b});
    if (busy_a === 1'b1) busy_a_run++;
    else if (busy_a_prev === 1'b1) begin busy_a_q.push_back(busy_a_run); busy_a_run = 0; end
    if (busy_b === 1'b1) busy_b_run++;
    else if (busy_b_prev === 1'b1) begin busy_b_q.push_back(busy_b_run); busy_b_run = 0; end
    busy_a_prev = busy_a;
    busy_b_prev = busy_b;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: parity bit on the line (1 = odd, 2 = even) and frame length.
  function automatic logic ref_par(input logic [8:0] d, input int par);
    int ones;
    ones = $countones(d);
    if (par == 2) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic int ref_frame_cycles(input int db, input int par, input int stop);
    return Cpb * (1 + db + ((par != 0) ? 1 : 0) + stop);
  endfunction

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    while (busy_a !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("tx_a_idle_before_send", busy_a, 1'b0);
    tx_data_a = d;
    tx_stb_a  = 1'b1;
    @(negedge clk);
    tx_stb_a  = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] d);
    int n = 0;
    while (busy_b !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("tx_b_idle_before_send", busy_b, 1'b0);
    tx_data_b = d;
    tx_stb_b  = 1'b1;
    @(negedge clk);
    tx_stb_b  = 1'b0;
  endtask

  task automatic get_frame_a(output rec_t r);
    int n = 0;
    while (rx_a_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    check("rx_a_frame_arrived", rx_a_q.size() != 0, 1);
    if (rx_a_q.size() != 0) r = rx_a_q.pop_front();
    else r = '1;
  endtask

  task automatic get_frame_b(output rec_t r);
    int n = 0;
    while (rx_b_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    check("rx_b_frame_arrived", rx_b_q.size() != 0, 1);
    if (rx_b_q.size() != 0) r = rx_b_q.pop_front();
    else r = '1;
  endtask

  task automatic loop_a_word(input logic [7:0] d);
    rec_t r;
    int   n = 0;
    int   len;
    busy_a_q.delete();
    send_a(d);
    get_frame_a(r);
    check("loop_a_data", r.data, {1'b0, d});
    check("loop_a_perr", r.perr, 1'b0);
    check("loop_a_ferr", r.ferr, 1'b0);
    while (busy_a !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    len = (busy_a_q.size() != 0) ? busy_a_q.pop_front() : -1;
    check("loop_a_busy_len", len, ref_frame_cycles(8, 2, 1));
  endtask

  task automatic loop_b_word(input logic [6:0] d);
    rec_t r;
    int   n = 0;
    int   len;
    busy_b_q.delete();
    send_b(d);
    get_frame_b(r);
    check("loop_b_data", r.data, {2'b0, d});
    check("loop_b_perr", r.perr, 1'b0);
    check("loop_b_ferr", r.ferr, 1'b0);
    while (busy_b !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    len = (busy_b_q.size() != 0) ? busy_b_q.pop_front() : -1;
    check("loop_b_busy_len", len, ref_frame_cycles(7, 1, 2));
  endtask

  // Drive one 8E1 frame onto core A's RX pin, optionally corrupting parity or stop.
  task automatic drive_rx_frame(input logic [7:0] d, input bit bad_par, input bit stop_val);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[9]   = ref_par({1'b0, d}, 2) ^ bad_par;
    bits[10]  = stop_val;
    for (int b = 0; b < 11; b++) begin
      rx_drv_a = bits[b];
      repeat (Cpb) @(negedge clk);
    end
    rx_drv_a = 1'b1;
  endtask

  task automatic rx_a_expect(input logic [7:0] d, input bit bad_par, input bit stop_val);
    rec_t r;
    drive_rx_frame(d, bad_par, stop_val);
    get_frame_a(r);
    check("rx_drv_data", r.data, {1'b0, d});
    check("rx_drv_perr", r.perr, bad_par);
    check("rx_drv_ferr", r.ferr, !stop_val);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t        r;
    int          n;
    logic [7:0]  d;
    logic [10:0] fbits;

    rst       = 1'b1;
    loop_a    = 1'b1;
    rx_drv_a  = 1'b1;
    tx_stb_a  = 1'b0;
    tx_data_a = '0;
    tx_stb_b  = 1'b0;
    tx_data_b = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", tx_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_rx_data", rx_data_a, 8'h00);
    check("rst_rx_valid", valid_a, 1'b0);
    check("rst_perr", perr_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_b_tx", tx_b, 1'b1);
    check("rst_b_busy", busy_b, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback, fixed then random words
    loop_a_word(8'hA5);
    for (int i = 0; i < 5; i++) loop_a_word(8'($urandom));

    // Back-to-back frames; a strobe while busy is dropped
    rx_a_q.delete();
    busy_a_q.delete();
    send_a(8'h00);
    n = 0;
    while (busy_a !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    check("b2b_busy_fell", busy_a, 1'b0);
    tx_data_a = 8'hFF;
    tx_stb_a  = 1'b1;
    @(negedge clk);
    tx_stb_a  = 1'b0;
    check("b2b_start_bit", tx_a, 1'b0);
    check("b2b_busy_again", busy_a, 1'b1);
    repeat (10) @(negedge clk);
    tx_data_a = 8'h77;
    tx_stb_a  = 1'b1;
    @(negedge clk);
    tx_stb_a  = 1'b0;
    get_frame_a(r);
    check("b2b_first", r.data, 9'h000);
    get_frame_a(r);
    check("b2b_second", r.data, 9'h0FF);
    repeat (150) @(negedge clk);
    check("b2b_only_two_frames", rx_a_q.size(), 0);
    check("b2b_two_busy_runs", busy_a_q.size(), 2);
    check("b2b_idle_after", busy_a, 1'b0);

    // Directly driven RX: parity error, then a good frame clears perr
    loop_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a_expect(8'h3C, 1'b1, 1'b1);
    rx_a_expect(8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rx_a_expect(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    // Framing error, then a glitch that must not start a frame
    rx_a_expect(8'hC6, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rx_a_q.delete();
    rx_drv_a = 1'b0;
    @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_frame", rx_a_q.size(), 0);
    check("glitch_ferr_held", ferr_a, 1'b1);
    check("glitch_data_held", rx_data_a, 8'hC6);
    check("glitch_perr_held", perr_a, 1'b0);

    // Reset mid-frame on both paths: TX in data bit 3, RX pin in data bit 5
    rx_a_q.delete();
    d = 8'($urandom);
    fbits = {1'b1, ref_par({1'b0, d}, 2), d, 1'b0};
    for (int c = 0; c < 30; c++) begin
      rx_drv_a  = (c >= 25) ? 1'b1 : fbits[c / Cpb];
      tx_data_a = 8'hC3;
      tx_stb_a  = (c == 6);
      rst       = (c == 25);
      @(negedge clk);
      if (c == 24) check("rst_mid_busy_before", busy_a, 1'b1);
      if (c == 25) begin
        check("rst_mid_tx_high", tx_a, 1'b1);
        check("rst_mid_busy_low", busy_a, 1'b0);
        check("rst_mid_no_valid", valid_a, 1'b0);
      end
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_mid_rx_discarded", rx_a_q.size(), 0);
    check("rst_mid_rx_data", rx_data_a, 8'h00);
    check("rst_mid_ferr", ferr_a, 1'b0);
    loop_a = 1'b1;
    repeat (4) @(negedge clk);
    loop_a_word(8'h5A);

    // 7O2 core
    loop_b_word(7'h41);
    for (int i = 0; i < 4; i++) loop_b_word(7'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
